bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
Sequential inverse of the combinational binary_to_BCD converter. It takes a 3-digit BCD value (HUNDREDS 2 bits, TENS 4 bits, ONES 4 bits; 0..399) and produces the 8-bit binary value.
- Uses reverse double-dabble: shift right, then subtract 3 from every digit that is >= 8.
- One bit is resolved per clock, under a start/busy/done handshake.
- Sits between SW-driven BCD entry and the counter load path (countercode D input / 8-bit datapath).
- Flags out-of-range (>255) and non-BCD inputs.

Parameters:
none. Widths are fixed: 8-bit binary, 2-bit hundreds, 4-bit tens/ones, 8 shift steps.

Ports:
clk       input   1  rising-edge clock
reset     input   1  synchronous, active-high reset
start     input   1  request conversion; sampled only in IDLE
HUNDREDS  input   2  BCD hundreds digit (0..3)
TENS      input   4  BCD tens digit (0..9 legal)
ONES      input   4  BCD ones digit (0..9 legal)
bin       output  8  result, value mod 256; held until next done
busy      output  1  high while converting
done      output  1  one-cycle pulse when bin/ovf/err are valid
ovf       output  1  input value > 255 (bin = value - 256)
err       output  1  TENS or ONES > 9; bin forced 0

Behaviour:
- Reset: the design has one clock; reset is synchronous and active-high.
  - Reset forces state=IDLE and clears bin=0, busy=0, done=0, ovf=0, err=0.
  - Reset asserted mid-conversion aborts it; no done pulse is issued.
  - Reset has priority over start.
- States: IDLE, CONV, FIN.
- IDLE, start=1, digits legal (sampled at edge E):
  - Load bcd_reg[11:0] = {2'b00, HUNDREDS, TENS, ONES} and bin_sh = 0.
  - Set step = 0, busy = 1, go to CONV.
- IDLE, start=1, TENS>9 or ONES>9:
  - Go to FIN with err_n = 1 and result 0.
  - done, err=1, bin=0 appear at edge E+1.
  - busy asserts for that single cycle.
- CONV, each edge:
  - {bcd_reg, bin_sh} shifts right by 1.
  - Then each of the 3 BCD nibbles of the shifted bcd_reg is decremented by 3 if >= 8; this is combinational, in the same edge.
  - step increments; after the 8th shift (step 7 -> 8) go to FIN.
  - Edges E+1..E+8 are shift edges.
- FIN, edge E+9:
  - bin <= bin_sh; ovf <= (bcd_reg != 0); err <= 0.
  - done = 1 for exactly this one cycle; busy = 0; return to IDLE.
- Latency: done is high in the cycle after edge E+9, i.e. 9 clocks after start is sampled. The next start can be accepted on the edge that ends the done cycle.
- start while busy (CONV/FIN) is ignored, not queued. Digit inputs are don't-care after E.
- bin/ovf/err keep their last values between done pulses. done is never asserted outside FIN.
- Arithmetic: all digit math is 4-bit unsigned, and the subtract only fires on values >= 8, so no underflow. HUNDREDS>3 is impossible by width.
- Back-to-back: start held high continuously gives one conversion every 10 clocks.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, CONV=2'd1, FIN=2'd2)
  - N_SHIFT=8
  - BCD_MAX=4'd9
  - SUB_THRESH=4'd8
- Natural sub-module: sub3 (4-bit in/out).
  - out = in-3 if in >= 8, else in.
  - Combinational inverse of add3.
  - Instantiated 3x on the shifted bcd_reg nibbles.
- FSM, step counter and output registers stay in bcd_to_binary_seq.

Test Plan:
- H=1,T=2,O=3, pulse start -> done exactly 9 clocks later; bin=8'h7B, ovf=0, err=0; busy high for 9 cycles.
- H=2,T=5,O=5 -> bin=8'hFF, ovf=0. Then H=2,T=5,O=6 -> bin=8'h00, ovf=1. Then H=3,T=9,O=9 -> bin=8'h8F, ovf=1.
- H=0,T=0,O=0 -> bin=0, ovf=0; done still at 9 clocks.
- T=4'hA, O=0, start -> done 1 clock after sampling; err=1, bin=0. Next legal start 0,4,2 -> bin=8'h2A, err cleared.
- Start 1,0,0; pulse start again at step 3; assert reset at step 5 -> no done, all outputs 0. New start 0,9,9 -> bin=8'h63 after 9 clocks.
- start held high for 30 clocks with 2,0,0 -> exactly 3 done pulses, 10 clocks apart, each bin=8'hC8.

Source files
------------

// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_binary_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int N_SHIFT = 8;
    localparam int STEP_W  = 4;
    localparam int BIN_W   = 8;
    localparam int BCD_W   = 12;

    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(N_SHIFT - 1);
    localparam logic [3:0]        BCD_MAX    = 4'd9;
    localparam logic [3:0]        SUB_THRESH = 4'd8;
    localparam logic [3:0]        SUB_AMT    = 4'd3;

    function automatic logic digit_legal(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_sub3.sv
// Digit correction for reverse double-dabble: a digit that picked up a
// shifted-in 8 is really worth 5, so subtract 3 (inverse of add3).
module bcd_to_binary_seq_sub3
    import bcd_to_binary_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= SUB_THRESH) ? din - SUB_AMT : din;
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter, one bit per clock,
// with start/busy/done handshake and overflow / non-BCD flags.
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       HUNDREDS,
    input  logic [3:0]       TENS,
    input  logic [3:0]       ONES,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
    logic               err_pend_q, err_pend_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               digits_ok;
    logic [BCD_W+BIN_W-1:0] shift_w;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [BIN_W-1:0]   bin_shifted;
    logic [BCD_W-1:0]   bcd_fixed;

    assign digits_ok = digit_legal(TENS) && digit_legal(ONES);

    // One reverse double-dabble step: shift the whole pair right, then correct digits.
    assign shift_w     = {bcd_q, bin_sh_q} >> 1;
    assign bcd_shifted = shift_w[BCD_W+BIN_W-1:BIN_W];
    assign bin_shifted = shift_w[BIN_W-1:0];

    for (genvar g = 0; g < 3; g++) begin : g_sub3
        bcd_to_binary_seq_sub3 u_sub3 (
            .din  (bcd_shifted[4*g +: 4]),
            .dout (bcd_fixed[4*g +: 4])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the datapath registers are reset too, so nothing in the
    // block ever carries X into the result after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            bcd_q      <= '0;
            bin_sh_q   <= '0;
            err_pend_q <= 1'b0;
            bin_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            bcd_q      <= bcd_d;
            bin_sh_q   <= bin_sh_d;
            err_pend_q <= err_pend_d;
            bin_q      <= bin_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = digits_ok ? ST_CONV : ST_FIN;
            ST_CONV: if (step_q == LAST_STEP) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_d     = step_q;
        bcd_d      = bcd_q;
        bin_sh_d   = bin_sh_q;
        err_pend_d = err_pend_q;
        bin_d      = bin_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_d   = '0;
                    bin_sh_d = '0;
                    // An illegal digit skips conversion; zeroed bcd keeps ovf clear.
                    if (digits_ok) begin
                        bcd_d      = {2'b00, HUNDREDS, TENS, ONES};
                        err_pend_d = 1'b0;
                    end else begin
                        bcd_d      = '0;
                        err_pend_d = 1'b1;
                    end
                end
            end
            ST_CONV: begin
                bcd_d    = bcd_fixed;
                bin_sh_d = bin_shifted;
                step_d   = step_q + 1'b1;
            end
            ST_FIN: begin
                bin_d  = bin_sh_q;
                ovf_d  = (bcd_q != '0);
                err_d  = err_pend_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign bin  = bin_q;
    assign ovf  = ovf_q;
    assign err  = err_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed scoreboard bench for bcd_to_binary_seq: every clock the monitor
// either retires the expected result due that cycle or demands done=0.
module tb_bcd_to_binary_seq;

    typedef struct {
        int         cyc;
        logic [7:0] bin;
        logic       ovf;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       err;

    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    bcd_to_binary_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .HUNDREDS (hundreds),
        .TENS     (tens),
        .ONES     (ones),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference from plain decimal arithmetic; cyc_e is the edge that samples start.
    function automatic exp_t model(input int cyc_e, input logic [1:0] h,
                                   input logic [3:0] t, input logic [3:0] o);
        exp_t e;
        int   v;
        v     = int'(h) * 100 + int'(t) * 10 + int'(o);
        e.err = (t > 4'd9) || (o > 4'd9);
        e.bin = e.err ? 8'd0 : v[7:0];
        e.ovf = !e.err && (v > 255);
        e.cyc = cyc_e + (e.err ? 1 : 9);
        return e;
    endfunction

    // Monitor samples 1 time unit after each edge; the main sequence acts at 2.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("done_pulse", 32'(done), 32'd1);
                check("bin", 32'(bin), 32'(e.bin));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("err", 32'(err), 32'(e.err));
            end else begin
                check("done_idle", 32'(done), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
        hundreds = h;
        tens     = t;
        ones     = o;
        start    = 1'b1;
        sb.push_back(model(cyc + 1, h, t, o));
        tick();
        start    = 1'b0;
        hundreds = 2'($urandom);
        tens     = 4'($urandom);
        ones     = 4'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int c0;
        reset    = 1'b1;
        start    = 1'b0;
        hundreds = '0;
        tens     = '0;
        ones     = '0;
        repeat (3) tick();
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // 123: busy for exactly 9 cycles, done on the 9th clock after sampling.
        launch(2'd1, 4'd2, 4'd3);
        for (int i = 0; i < 9; i++) begin
            check("busy_conv", 32'(busy), 32'd1);
            tick();
        end
        check("busy_done_cycle", 32'(busy), 32'd0);
        wait_drain(20);

        launch(2'd2, 4'd5, 4'd5);
        wait_drain(20);
        launch(2'd2, 4'd5, 4'd6);
        wait_drain(20);
        launch(2'd3, 4'd9, 4'd9);
        wait_drain(20);
        launch(2'd0, 4'd0, 4'd0);
        wait_drain(20);

        // Non-BCD tens digit: one busy cycle, then done with err.
        launch(2'd0, 4'hA, 4'd0);
        check("busy_err", 32'(busy), 32'd1);
        wait_drain(20);
        launch(2'd0, 4'd4, 4'd2);
        wait_drain(20);

        // Abort: extra start mid-conversion is ignored, reset kills the result.
        launch(2'd1, 4'd0, 4'd0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        check("abort_bin", 32'(bin), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        check("abort_busy_after", 32'(busy), 32'd0);
        launch(2'd0, 4'd9, 4'd9);
        wait_drain(20);

        // start held for 30 clocks: conversions accepted every 10 clocks.
        hundreds = 2'd2;
        tens     = 4'd0;
        ones     = 4'd0;
        start    = 1'b1;
        c0       = cyc + 1;
        for (int k = 0; k < 3; k++) sb.push_back(model(c0 + 10 * k, 2'd2, 4'd0, 4'd0));
        repeat (30) tick();
        start = 1'b0;
        wait_drain(20);
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
